// File: rtl/vdp_io_if.sv
// CPU-side bus of the VDP: port select, write/read strobes and data in both directions.
// The CPU (or a bench standing in for it) takes the master view; vdp_io takes the slave view.
interface vdp_io_if;
  logic       cpu_port;
  logic [7:0] cpu_din;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] cpu_dout;

  modport master (output cpu_port, cpu_din, cpu_wr, cpu_rd, input  cpu_dout);
  modport slave  (input  cpu_port, cpu_din, cpu_wr, cpu_rd, output cpu_dout);
endinterface

// File: rtl/vdp_io.sv
// TMS9918-style VDP CPU port: data/control port decode, auto-incrementing VRAM address,
// read-ahead buffer, R0-R7, status flags, interrupt and static video configuration outputs.
module vdp_io #(
  parameter logic [7:0] R1_RESET = 8'h40,
  parameter logic [7:0] R7_RESET = 8'hF4
) (
  input  logic        clk,
  input  logic        reset,
  vdp_io_if.slave     cpu,
  output logic [13:0] vga_addr,
  output logic [7:0]  vga_din,
  output logic        vga_wr,
  output logic        vga_rd,
  input  logic [7:0]  vga_dout,
  output logic [1:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic        video_on,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic        vert_retrace_int,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  input  logic        frame_int,
  input  logic        sprite_collision,
  input  logic [4:0]  sprite5,
  output logic        n_int
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD_REQ, ST_RD_CAP, ST_WR} acc_state_t;

  acc_state_t       state, state_next;
  logic [7:0][7:0]  regs;
  logic [13:0]      addr;
  logic [7:0]       latch, buffer, dout_q;
  logic             toggle, f_flag, c_flag;
  logic             wr_ctrl, wr_data, rd_data, rd_stat, second_byte, set_addr, start_fetch;

  // A simultaneous write wins: the read strobe is masked out whenever cpu_wr is high.
  assign wr_ctrl     = cpu.cpu_wr & cpu.cpu_port;
  assign wr_data     = cpu.cpu_wr & ~cpu.cpu_port;
  assign rd_data     = cpu.cpu_rd & ~cpu.cpu_wr & ~cpu.cpu_port;
  assign rd_stat     = cpu.cpu_rd & ~cpu.cpu_wr & cpu.cpu_port;
  assign second_byte = wr_ctrl & toggle;
  assign set_addr    = second_byte & ~cpu.cpu_din[7];
  assign start_fetch = rd_data | (set_addr & ~cpu.cpu_din[6]);

  assign vga_addr     = addr;
  assign cpu.cpu_dout = dout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // VRAM access sequencer: a prefetch spends one cycle requesting and one capturing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    vga_rd     = 1'b0;
    vga_wr     = 1'b0;
    case (state)
      ST_RD_REQ: begin
        vga_rd     = 1'b1;
        state_next = ST_RD_CAP;
      end
      ST_RD_CAP: state_next = ST_IDLE;
      ST_WR: begin
        vga_wr     = 1'b1;
        state_next = ST_IDLE;
      end
      default: ;
    endcase
    if (wr_data)          state_next = ST_WR;
    else if (start_fetch) state_next = ST_RD_REQ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is eight flops, not a RAM, so resetting it as a whole is cheap and safe.
      regs    <= {R7_RESET, 40'h0, R1_RESET, 8'h00};
      addr    <= '0;
      latch   <= '0;
      buffer  <= '0;
      dout_q  <= '0;
      vga_din <= '0;
      toggle  <= 1'b0;
      f_flag  <= 1'b0;
      c_flag  <= 1'b0;
      n_int   <= 1'b1;
    end else begin
      // NOTE: non-blocking throughout; the strobe handling below deliberately overrides the
      // increment above it because the last scheduled assignment wins.
      if (state == ST_RD_CAP) begin
        buffer <= vga_dout;
        addr   <= addr + 14'd1;
      end
      if (state == ST_WR) addr <= addr + 14'd1;

      // Setting a flag beats the clear from a status read in the same cycle.
      f_flag <= frame_int | (f_flag & ~rd_stat);
      c_flag <= (sprite_collision & regs[1][6]) | (c_flag & ~rd_stat);
      n_int  <= ~(f_flag & regs[1][5]);

      if (wr_ctrl) begin
        if (!toggle) begin
          latch  <= cpu.cpu_din;
          toggle <= 1'b1;
        end else begin
          toggle <= 1'b0;
          if (cpu.cpu_din[7]) regs[cpu.cpu_din[2:0]] <= latch;
          else                addr <= {cpu.cpu_din[5:0], latch};
        end
      end else if (wr_data) begin
        vga_din <= cpu.cpu_din;
        buffer  <= cpu.cpu_din;
        toggle  <= 1'b0;
      end else if (rd_data) begin
        dout_q <= buffer;
        toggle <= 1'b0;
      end else if (rd_stat) begin
        dout_q <= {f_flag, 1'b0, c_flag, sprite5};
        toggle <= 1'b0;
      end
    end
  end

  always_comb begin
    if (regs[1][4])      mode = 2'd0;
    else if (regs[1][3]) mode = 2'd3;
    else if (regs[0][1]) mode = 2'd2;
    else                 mode = 2'd1;

    name_table_addr           = {regs[2][3:0], 10'b0};
    sprite_attr_addr          = {regs[5][6:0], 7'b0};
    sprite_pattern_table_addr = {regs[6][2:0], 11'b0};
    // Graphics II splits colour and pattern tables into 8K halves selected by one bit each.
    if (mode == 2'd2) begin
      color_table_addr = {regs[3][7], 13'b0};
      font_addr        = {regs[4][2], 13'b0};
    end else begin
      color_table_addr = {regs[3], 6'b0};
      font_addr        = {regs[4][2:0], 11'b0};
    end

    video_on         = regs[1][6];
    vert_retrace_int = regs[1][5];
    sprite_large     = regs[1][1];
    sprite_enlarged  = regs[1][0];
    text_color       = regs[7][7:4];
    back_color       = regs[7][3:0];
  end

endmodule

// File: tb/tb_vdp_io.sv
// Self-checking bench for vdp_io: directed scenarios plus random CPU traffic, compared
// against a transaction-level model of the port behaviour and a behavioural VRAM.
module tb_vdp_io;
  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] vga_addr;
  logic [7:0]  vga_din, vga_dout;
  logic        vga_wr, vga_rd;
  logic [1:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, sprite_large, sprite_enlarged, vert_retrace_int;
  logic [3:0]  text_color, back_color;
  logic        frame_int, sprite_collision, n_int;
  logic [4:0]  sprite5;

  vdp_io_if cpu_bus();

  vdp_io dut (
    .clk(clk), .reset(reset), .cpu(cpu_bus),
    .vga_addr(vga_addr), .vga_din(vga_din), .vga_wr(vga_wr), .vga_rd(vga_rd), .vga_dout(vga_dout),
    .mode(mode), .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
    .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr),
    .video_on(video_on), .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
    .vert_retrace_int(vert_retrace_int), .text_color(text_color), .back_color(back_color),
    .frame_int(frame_int), .sprite_collision(sprite_collision), .sprite5(sprite5), .n_int(n_int)
  );

  always #5 clk = ~clk;

  // Behavioural VRAM with one-cycle read latency; also logs every access the DUT makes.
  logic [7:0]  vram [16384];
  int          wr_cnt = 0, rd_cnt = 0;
  logic [13:0] last_wr_addr = '0;
  logic [7:0]  last_wr_data = '0;

  always @(posedge clk) begin
    if (vga_wr) begin
      vram[vga_addr] = vga_din;
      wr_cnt++;
      last_wr_addr = vga_addr;
      last_wr_data = vga_din;
    end
    if (vga_rd) begin
      vga_dout <= vram[vga_addr];
      rd_cnt++;
    end
  end

  // Reference model state.
  logic [7:0]  m_reg [8];
  logic [7:0]  m_mem [16384];
  logic [13:0] m_addr;
  logic [7:0]  m_buf, m_latch;
  bit          m_tog, m_f, m_c;
  int          exp_wr = 0, exp_rd = 0;
  logic [13:0] exp_wr_addr = '0;
  logic [7:0]  exp_wr_data = '0;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_reg[1] = 8'h40;
    m_reg[7] = 8'hF4;
    m_addr = '0; m_buf = '0; m_latch = '0;
    m_tog = 0; m_f = 0; m_c = 0;
  endtask

  task automatic model_prefetch();
    m_buf  = m_mem[m_addr];
    m_addr = m_addr + 14'd1;
    exp_rd++;
  endtask

  function automatic logic [1:0] exp_mode();
    if (m_reg[1][4])      return 2'd0;
    else if (m_reg[1][3]) return 2'd3;
    else if (m_reg[0][1]) return 2'd2;
    return 2'd1;
  endfunction

  task automatic check_all();
    logic g2;
    g2 = (exp_mode() == 2'd2);
    check("vga_addr", {2'b0, vga_addr}, {2'b0, m_addr});
    check("wr_count", wr_cnt[15:0], exp_wr[15:0]);
    check("wr_addr", {2'b0, last_wr_addr}, {2'b0, exp_wr_addr});
    check("wr_data", {8'b0, last_wr_data}, {8'b0, exp_wr_data});
    check("rd_count", rd_cnt[15:0], exp_rd[15:0]);
    check("idle_strobes", {14'b0, vga_wr, vga_rd}, 16'h0);
    check("n_int", {15'b0, n_int}, {15'b0, ~(m_f & m_reg[1][5])});
    check("mode", {14'b0, mode}, {14'b0, exp_mode()});
    check("name_tab", {2'b0, name_table_addr}, 16'(m_reg[2][3:0]) * 16'h0400);
    check("color_tab", {2'b0, color_table_addr}, g2 ? (m_reg[3][7] ? 16'h2000 : 16'h0000) : 16'(m_reg[3]) * 16'd64);
    check("font", {2'b0, font_addr}, g2 ? (m_reg[4][2] ? 16'h2000 : 16'h0000) : 16'(m_reg[4][2:0]) * 16'h0800);
    check("spr_attr", {2'b0, sprite_attr_addr}, 16'(m_reg[5][6:0]) * 16'd128);
    check("spr_pat", {2'b0, sprite_pattern_table_addr}, 16'(m_reg[6][2:0]) * 16'h0800);
    check("flags", {12'b0, video_on, vert_retrace_int, sprite_large, sprite_enlarged},
          {12'b0, m_reg[1][6], m_reg[1][5], m_reg[1][1], m_reg[1][0]});
    check("colors", {8'b0, text_color, back_color}, {8'b0, m_reg[7]});
  endtask

  // One strobe cycle followed by idle time so the DUT's access sequence has fully settled.
  task automatic bus_cycle(input bit port, input bit wr, input bit rd, input logic [7:0] d, input bit fr);
    @(negedge clk);
    cpu_bus.cpu_port = port; cpu_bus.cpu_din = d;
    cpu_bus.cpu_wr = wr; cpu_bus.cpu_rd = rd; frame_int = fr;
    @(negedge clk);
    cpu_bus.cpu_wr = 1'b0; cpu_bus.cpu_rd = 1'b0; frame_int = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ctrl_w(input logic [7:0] b);
    bus_cycle(1'b1, 1'b1, 1'b0, b, 1'b0);
    if (!m_tog) begin
      m_latch = b; m_tog = 1;
    end else begin
      m_tog = 0;
      if (b[7]) m_reg[b[2:0]] = m_latch;
      else begin
        m_addr = {b[5:0], m_latch};
        if (!b[6]) model_prefetch();
      end
    end
    check_all();
  endtask

  task automatic data_w(input logic [7:0] b);
    bus_cycle(1'b0, 1'b1, 1'b0, b, 1'b0);
    m_mem[m_addr] = b;
    exp_wr++; exp_wr_addr = m_addr; exp_wr_data = b;
    m_buf = b; m_addr = m_addr + 14'd1; m_tog = 0;
    check_all();
  endtask

  task automatic data_r();
    logic [7:0] e;
    bus_cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    e = m_buf;
    model_prefetch();
    m_tog = 0;
    check("data_rd", {8'b0, cpu_bus.cpu_dout}, {8'b0, e});
    check_all();
  endtask

  task automatic stat_r(input bit fr);
    logic [7:0] e;
    e = {m_f, 1'b0, m_c, sprite5};
    bus_cycle(1'b1, 1'b0, 1'b1, 8'h00, fr);
    m_f = fr; m_c = 0; m_tog = 0;
    check("status", {8'b0, cpu_bus.cpu_dout}, {8'b0, e});
    check_all();
  endtask

  task automatic pulse(input bit fr, input bit coll);
    @(negedge clk);
    frame_int = fr; sprite_collision = coll;
    @(negedge clk);
    frame_int = 1'b0; sprite_collision = 1'b0;
    repeat (2) @(negedge clk);
    if (fr) m_f = 1;
    if (coll && m_reg[1][6]) m_c = 1;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int rd_before;
    for (int i = 0; i < 16384; i++) begin
      vram[i]  = 8'($urandom);
      m_mem[i] = vram[i];
    end
    vga_dout = '0;
    cpu_bus.cpu_port = 1'b0; cpu_bus.cpu_din = '0; cpu_bus.cpu_wr = 1'b0; cpu_bus.cpu_rd = 1'b0;
    frame_int = 1'b0; sprite_collision = 1'b0; sprite5 = 5'h0B;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout", {8'b0, cpu_bus.cpu_dout}, 16'h0000);
    check("rst_mode", {14'b0, mode}, 16'd1);
    check_all();

    // Register writes and mode decode.
    ctrl_w(8'h3F); ctrl_w(8'h82);
    check("name_3c00", {2'b0, name_table_addr}, 16'h3C00);
    ctrl_w(8'h10); ctrl_w(8'h81);
    check("mode_text", {14'b0, mode}, 16'd0);
    ctrl_w(8'h02); ctrl_w(8'h80);
    ctrl_w(8'h04); ctrl_w(8'h84);
    ctrl_w(8'h00); ctrl_w(8'h81);
    check("mode_g2", {14'b0, mode}, 16'd2);
    check("font_g2", {2'b0, font_addr}, 16'h2000);

    // Address wrap on data writes.
    ctrl_w(8'hFF); ctrl_w(8'h7F);
    data_w(8'hAA);
    check("wrap_wr0", {2'b0, last_wr_addr, 8'b0} >> 8, 16'h3FFF);
    data_w(8'h55);
    check("wrap_wr1", {2'b0, last_wr_addr}, 16'h0000);
    check("wrap_end", {2'b0, vga_addr}, 16'h0001);

    // Read-ahead through the buffer.
    vram[14'h0100] = 8'h12; m_mem[14'h0100] = 8'h12;
    vram[14'h0101] = 8'h34; m_mem[14'h0101] = 8'h34;
    ctrl_w(8'h00); ctrl_w(8'h01);
    data_r();
    check("rd_12", {8'b0, cpu_bus.cpu_dout}, 16'h0012);
    data_r();
    check("rd_34", {8'b0, cpu_bus.cpu_dout}, 16'h0034);

    // Frame interrupt and status clear.
    ctrl_w(8'h60); ctrl_w(8'h81);
    pulse(1'b1, 1'b0);
    check("nint_low", {15'b0, n_int}, 16'h0000);
    stat_r(1'b0);
    check("stat_f1", {15'b0, cpu_bus.cpu_dout[7]}, 16'h0001);
    check("nint_high", {15'b0, n_int}, 16'h0001);
    stat_r(1'b0);
    check("stat_f0", {15'b0, cpu_bus.cpu_dout[7]}, 16'h0000);

    // Status read resets the control-byte toggle.
    ctrl_w(8'h12); stat_r(1'b0); ctrl_w(8'h34); ctrl_w(8'h40);
    check("toggle_addr", {2'b0, vga_addr}, 16'h0034);

    // Frame pulse coincident with a status read: set wins, old value returned.
    stat_r(1'b1);
    check("coinc_old", {15'b0, cpu_bus.cpu_dout[7]}, 16'h0000);
    stat_r(1'b0);
    check("coinc_kept", {15'b0, cpu_bus.cpu_dout[7]}, 16'h0001);

    // Collision flag only while the display is on.
    pulse(1'b0, 1'b1);
    stat_r(1'b0);

    // Random traffic.
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      sprite5 = 5'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: ctrl_w(8'($urandom));
        3, 4:    data_w(8'($urandom));
        5, 6:    data_r();
        7:       stat_r(1'($urandom));
        8:       pulse(1'b1, 1'b0);
        default: pulse(1'b0, 1'b1);
      endcase
    end

    // Reset while a prefetch request is on the VRAM bus.
    if (m_tog) ctrl_w(8'h00);
    ctrl_w(8'h00);
    @(negedge clk);
    cpu_bus.cpu_port = 1'b1; cpu_bus.cpu_din = 8'h05; cpu_bus.cpu_wr = 1'b1;
    @(negedge clk);
    cpu_bus.cpu_wr = 1'b0;
    check("pf_pending", {15'b0, vga_rd}, 16'h0001);
    rd_before = rd_cnt;
    reset = 1'b1;
    #1;
    check("rst_rd", {15'b0, vga_rd}, 16'h0000);
    check("rst_nint", {15'b0, n_int}, 16'h0001);
    check("rst_addr", {2'b0, vga_addr}, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    model_reset();
    exp_rd = exp_rd + 0;
    check("no_rd_after", rd_cnt[15:0], 16'(rd_before));
    exp_rd = rd_before;
    check_all();
    data_r();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vdp_io.md
Name: vdp_io

Overview:
- CPU-side port interface of the TMS9918-style VDP. Decodes CPU accesses to the data port (port 0) and control port (port 1).
- Owns the 14-bit auto-incrementing VRAM address, the read-ahead buffer, registers R0–R7 and the status register.
- Drives the VRAM port-A signals and all static configuration inputs of the downstream video generator: mode, table bases, colours, sprite flags and interrupt enable.
- Generates the CPU interrupt from the video generator's frame pulse.

Parameters:
- R1_RESET, 8'h40: reset value of R1 (screen enabled, text mode off, IE off).
- R7_RESET, 8'hF4: reset value of R7 (text colour 15, back colour 4).

Ports:
- clk  in  1  system clock; also the VRAM port-A clock.
- reset  in  1  asynchronous, active-high.
- cpu_port  in  1  0 = data port, 1 = control port.
- cpu_din  in  8  CPU write data.
- cpu_wr  in  1  one-cycle write strobe.
- cpu_rd  in  1  one-cycle read strobe.
- cpu_dout  out  8  read data, registered.
- vga_addr  out  14  VRAM address.
- vga_din  out  8  VRAM write data.
- vga_wr  out  1  VRAM write pulse.
- vga_rd  out  1  VRAM read pulse.
- vga_dout  in  8  VRAM read data, valid the cycle after vga_rd.
- mode  out  2  0 text, 1 graphics I, 2 graphics II, 3 multicolour.
- name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr  out  14 each.
- video_on, sprite_large, sprite_enlarged, vert_retrace_int  out  1 each.
- text_color, back_color  out  4 each.
- frame_int  in  1  one-cycle frame-end pulse from the video generator.
- sprite_collision  in  1.
- sprite5  in  5.
- n_int  out  1  active-low CPU interrupt.

Behaviour:
- Reset (async): R0, R2–R6 = 0; R1 = R1_RESET; R7 = R7_RESET; address = 0; toggle = 0; latch = 0; read buffer = 0; F = 0; C = 0; cpu_dout = 0; vga_wr = vga_rd = 0; n_int = 1.
- Simultaneous cpu_wr and cpu_rd: write served, read ignored.
- Strobes are at least 3 clocks apart; closer strobes are out of contract.
- Control write, toggle = 0: latch <= cpu_din; toggle <= 1.
- Control write, toggle = 1 (toggle <= 0 in every case):
  - din[7] = 1: R[din[2:0]] <= latch.
  - din[7:6] = 01: address <= {din[5:0], latch}.
  - din[7:6] = 00: address <= {din[5:0], latch}, then a prefetch is started.
- Prefetch: cycle N+1 vga_rd = 1 with vga_addr = address; cycle N+2 buffer <= vga_dout and address <= address + 1.
- Data write: cycle N+1 vga_wr = 1, vga_addr = address, vga_din = cpu_din; buffer <= cpu_din; address <= address + 1 at N+2; toggle <= 0.
- Data read: cpu_dout <= buffer at N+1, then a prefetch is started; toggle <= 0.
- Address increment wraps 3FFF -> 0000.
- Status read: cpu_dout <= {F, 5S = 0, C, sprite5}; F and C cleared; toggle <= 0.
- F set on frame_int.
- C set on sprite_collision while video_on.
- Set beats clear when both occur in the same cycle; the status read still returns the pre-set value.
- n_int = !(F & R1[5]), registered.
- Mode decode (priority order): R1[4] -> mode 0; else R1[3] -> mode 3; else R0[1] -> mode 2; else mode 1.
- Table bases:
  - name_table_addr = {R2[3:0], 10'b0}.
  - sprite_attr_addr = {R5[6:0], 7'b0}.
  - sprite_pattern_table_addr = {R6[2:0], 11'b0}.
  - Modes 0/1/3: color_table_addr = {R3, 6'b0} and font_addr = {R4[2:0], 11'b0}.
  - Mode 2: color_table_addr = {R3[7], 13'b0} and font_addr = {R4[2], 13'b0}.
- Flag outputs: video_on = R1[6]; vert_retrace_int = R1[5]; sprite_large = R1[1]; sprite_enlarged = R1[0]; text_color = R7[7:4]; back_color = R7[3:0].
- Register writes take effect the cycle after the second control byte.
- Reset mid-prefetch aborts the prefetch; no vga_rd is issued after reset releases.

Test Plan:
- Control writes 0x3F, 0x82 -> R2 = 0x3F and name_table_addr = 0x3C00. Then 0x10, 0x81 -> mode 0; then 0x00, 0x81 with R0 = 0x02 -> mode 2 and font_addr follows R4[2].
- Control writes 0xFF, 0x7F, then data writes 0xAA, 0x55 -> vga_wr at 3FFF with 0xAA, then at 0000 with 0x55; address ends at 0001.
- Preload VRAM[0x0100] = 0x12 and [0x0101] = 0x34; control writes 0x00, 0x01; two data reads -> cpu_dout = 0x12, then 0x34; one vga_rd per read plus one at setup.
- Set R1 = 0x60; pulse frame_int -> n_int = 0. Status read -> cpu_dout[7] = 1, then n_int = 1. Second status read -> cpu_dout[7] = 0.
- Single control write 0x12, then status read, then control writes 0x34, 0x40 -> address = 0x0034 (toggle reset by status read); latch = 0x34.
- frame_int in the same cycle as a status read -> returned bit7 = old value, F remains 1. Assert reset during a pending prefetch -> all outputs at reset values, no vga_rd afterwards.
